// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one outstanding word fetch, valid/ready hand-off to decode.
// Define IFU_PERF_EN to build the delivered/stall performance counters.
module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fetch_err,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic        kill_q;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
    assign mem_req_addr = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StReq;
            pc_q          <= RESET_PC;
            kill_q        <= 1'b0;
            mem_req_valid <= 1'b1;
            inst_valid    <= 1'b0;
            inst          <= 32'h0;
            inst_pc       <= 32'h0;
            fetch_err     <= 1'b0;
        end else begin
            unique case (state_q)
                StReq: begin
                    if (redirect_valid) begin
                        pc_q <= redirect_tgt;
                    end
                    if (mem_req_ready) begin
                        // A redirect racing the accept leaves the old fetch in flight.
                        state_q       <= StWait;
                        mem_req_valid <= 1'b0;
                        kill_q        <= redirect_valid;
                    end
                end
                StWait: begin
                    if (mem_rsp_valid) begin
                        if (kill_q || redirect_valid) begin
                            kill_q        <= 1'b0;
                            state_q       <= StReq;
                            mem_req_valid <= 1'b1;
                            if (redirect_valid) begin
                                pc_q <= redirect_tgt;
                            end
                        end else begin
                            inst       <= mem_rsp_err ? NOP_INST : mem_rsp_data;
                            inst_pc    <= pc_q;
                            fetch_err  <= mem_rsp_err;
                            inst_valid <= 1'b1;
                            state_q    <= StHold;
                        end
                    end else if (redirect_valid) begin
                        kill_q <= 1'b1;
                        pc_q   <= redirect_tgt;
                    end
                end
                StHold: begin
                    if (redirect_valid || inst_ready) begin
                        inst_valid    <= 1'b0;
                        state_q       <= StReq;
                        mem_req_valid <= 1'b1;
                        pc_q          <= redirect_valid ? redirect_tgt : pc_q + 32'd4;
                    end
                end
                default: begin
                    state_q       <= StReq;
                    mem_req_valid <= 1'b1;
                end
            endcase
        end
    end

`ifdef IFU_PERF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetch_cnt <= 32'h0;
            perf_stall_cnt <= 32'h0;
        end else if (inst_valid) begin
            if (inst_ready) begin
                perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            end else begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
        end
    end
`else
    assign perf_fetch_cnt = 32'h0;
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly upstream of the decode stage.
- Holds the PC and issues one word fetch at a time over a valid/ready request channel with a valid-only response channel.
- Presents the fetched instruction word and its PC to decode through a valid/ready handshake.
- Accepts redirects (jump, branch, trap) from later stages and discards any in-flight fetch for the old path.

Parameters:
- RESET_PC, 32'h8000_0000, PC loaded on reset.
- NOP_INST, 32'h0000_0013, word driven on inst when a fetch returns an error.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- mem_req_valid  output  1  fetch request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  32  fetch address, word aligned
- mem_rsp_valid  input  1  response valid, one-cycle pulse, no backpressure
- mem_rsp_data  input  32  fetched word
- mem_rsp_err  input  1  access fault, qualified by mem_rsp_valid
- inst_valid  output  1  inst/inst_pc valid toward decode
- inst_ready  input  1  decode accepts
- inst  output  32  instruction word
- inst_pc  output  32  PC of inst
- fetch_err  output  1  inst came from a faulted fetch
- redirect_valid  input  1  redirect request, single-cycle
- redirect_pc  input  32  redirect target
- perf_fetch_cnt  output  32  delivered-instruction counter
- perf_stall_cnt  output  32  cycles with inst_valid=1 and inst_ready=0

Behaviour:
- Single clock clk; reset rst is synchronous and active-high. All outputs are registered.
- Reset values: pc=RESET_PC, state=REQ, mem_req_valid=1 on the first cycle after reset, inst_valid=0, inst=0, inst_pc=0, fetch_err=0, kill=0, both perf counters=0.
- States:
  - REQ: mem_req_valid=1, mem_req_addr=pc. On mem_req_ready go to WAIT.
  - WAIT: waiting for mem_rsp_valid. On response with kill=0, latch inst=mem_rsp_data (NOP_INST if mem_rsp_err), inst_pc=pc, fetch_err=mem_rsp_err, set inst_valid, go to HOLD.
  - HOLD: inst_valid=1. On inst_ready, clear inst_valid, pc<=pc+4 (wraps mod 2^32), go to REQ.
- Minimum latency: request accepted at cycle N, response at N+1, inst_valid at N+2. Back-to-back throughput is one instruction per 3 cycles.
- Stability: inst, inst_pc and fetch_err are held stable while inst_valid=1 and inst_ready=0. mem_req_addr is held stable while mem_req_valid=1 and mem_req_ready=0.
- Redirect target: pc<={redirect_pc[31:2],2'b00}. Low two bits are always dropped.
- Redirect in REQ, no accept: new address is driven next cycle, state stays REQ.
- Redirect in REQ, same-cycle mem_req_ready: the old request is outstanding. Go to WAIT with kill=1.
- Redirect in WAIT, no response this cycle: kill<=1.
- WAIT with kill=1 and a response: drop the response, clear kill, go to REQ at the new pc.
- Redirect in WAIT with a response in the same cycle: drop the response, go to REQ at the redirect pc.
- Redirect in HOLD: clear inst_valid, go to REQ at the redirect pc.
  - If inst_ready is also high, the instruction counts as delivered and perf_fetch_cnt increments.
  - The redirect PC overrides the pc+4 update.
- A redirect taking effect and a pending kill never coexist except as described above. A kill always consumes exactly one response.
- mem_rsp_valid outside WAIT is a protocol violation; it is ignored and causes no state change.
- Reset mid-operation: any outstanding memory response arriving after reset is ignored, because state=REQ. The memory side must not return a stale response after a reset.

Optional Feature:
- Macro IFU_PERF_EN.
- Defined: perf_fetch_cnt increments on each cycle with inst_valid && inst_ready. perf_stall_cnt increments on each cycle with inst_valid && !inst_ready. Both wrap mod 2^32 and are cleared by rst.
- Undefined: no counter registers exist; both ports are driven constant 0.

Test Plan:
- Reset, mem_req_ready=1, response at +1 with data 32'h00000093, inst_ready=1 -> mem_req_addr=32'h8000_0000; inst_valid at cycle 3 with inst=32'h00000093, inst_pc=32'h8000_0000; next request addr 32'h8000_0004.
- Hold inst_ready=0 for 5 cycles in HOLD -> inst and inst_pc stable, no new mem_req_valid, perf_stall_cnt=5 (IFU_PERF_EN defined).
- Redirect to 32'h8000_0103 while in WAIT, response arrives next cycle -> response dropped, inst_valid stays 0, next mem_req_addr=32'h8000_0100.
- Redirect to 32'h8000_0200 in the same cycle the request is accepted, response 32'hDEADBEEF -> never presented; following fetch at 32'h8000_0200.
- Response with mem_rsp_err=1 -> inst=32'h00000013, fetch_err=1; after handshake, next addr is pc+4 and fetch_err=0 on the next good fetch.
- Redirect in HOLD with inst_ready=1 at pc 32'hFFFF_FFFC -> perf_fetch_cnt increments, next addr is the redirect target not 0. Separately, a normal advance from 32'hFFFF_FFFC wraps to 32'h0000_0000.
